// File: rtl/encoder_4to2_seq_pkg.sv
// Shared definitions for the sequential 4-to-2 request encoder.
// Holds the FSM state encodings, code/request widths and a code-to-one-hot helper.
package encoder_4to2_seq_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   localparam int CODE_W = 2;
   localparam int N_REQ  = 4;

   typedef logic [CODE_W-1:0] code_t;
   typedef logic [N_REQ-1:0]  req_t;

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_HOLD = ST_HOLD
   } state_e;

   function automatic req_t code2onehot(input code_t c);
      req_t r;
      r = '0;
      r[c] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/encoder_4to2_seq_prio_enc4.sv
// Combinational 4-input priority encoder with optional rotating search origin.
// rr_en=0 gives fixed priority (3 highest); rr_en=1 scans upward from base, wrapping 3 -> 0.
module prio_enc4
   import encoder_4to2_seq_pkg::*;
(
   input  logic [N_REQ-1:0]  req,
   input  logic [CODE_W-1:0] base,
   input  logic              rr_en,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   logic [CODE_W-1:0] w_pos;
   logic              w_found;

   assign any = |req;

   always_comb begin
      idx     = '0;
      w_pos   = '0;
      w_found = 1'b0;
      if (rr_en) begin
         for (int k = 0; k < N_REQ; k++) begin
            // Two-bit addition wraps naturally, giving the 3 -> 0 rollover.
            w_pos = base + CODE_W'(k);
            if (!w_found && req[w_pos]) begin
               idx     = w_pos;
               w_found = 1'b1;
            end
         end
      end else begin
         if (req[3])      idx = 2'd3;
         else if (req[2]) idx = 2'd2;
         else if (req[1]) idx = 2'd1;
         else             idx = 2'd0;
      end
   end

endmodule

// File: rtl/encoder_4to2_seq.sv
// Sequential 4-to-2 encoder: sticky pending bits, one grant at a time, V/ACK handshake.
// All outputs come straight from registers; selection looks at the pending register only.
module encoder_4to2_seq
   import encoder_4to2_seq_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             EN,
   input  logic             D0,
   input  logic             D1,
   input  logic             D2,
   input  logic             D3,
   input  logic             ACK,
   output logic             A1,
   output logic             A0,
   output logic             V,
   output logic [N_REQ-1:0] PEND
);

   state_e            r_state;
   req_t              r_pend;
   code_t             r_code;
   logic              r_v;
   code_t             r_ptr;

   req_t              w_req;
   req_t              w_clr;
   logic              w_accept;
   code_t             w_base;
   code_t             w_idx;
   logic              w_any;

   assign w_req    = {D3, D2, D1, D0};
   assign w_accept = ACK & r_v;
   assign w_clr    = w_accept ? code2onehot(r_code) : '0;
   assign w_base   = r_ptr + 2'd1;

   prio_enc4 u_prio (
      .req   (r_pend),
      .base  (w_base),
      .rr_en (ROUND_ROBIN),
      .idx   (w_idx),
      .any   (w_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_code  <= '0;
         r_v     <= 1'b0;
         r_ptr   <= 2'd3;
      end else if (!EN) begin
         // Flush everything except the round-robin pointer.
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_code  <= '0;
         r_v     <= 1'b0;
      end else begin
         // New requests are OR-ed in after the clear, so a colliding request survives.
         r_pend <= (r_pend & ~w_clr) | w_req;
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_code  <= w_idx;
                  r_v     <= 1'b1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (ACK) begin
                  r_v     <= 1'b0;
                  r_ptr   <= r_code;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_v     <= 1'b0;
            end
         endcase
      end
   end

   assign A1   = r_code[1];
   assign A0   = r_code[0];
   assign V    = r_v;
   assign PEND = r_pend;

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// Scoreboard bench for encoder_4to2_seq: a fixed-priority and a round-robin instance.
// Stimulus pushes expected grant codes; a negedge monitor pops them on each accepted handshake.
module tb_encoder_4to2_seq;

   logic       clk;
   logic       rst;
   logic       en   [2];
   logic [3:0] d    [2];
   logic       ack  [2];
   logic       a1   [2];
   logic       a0   [2];
   logic       v    [2];
   logic [3:0] pend [2];

   int n_vec = 0;
   int n_err = 0;
   int q0[$];
   int q1[$];

   encoder_4to2_seq #(.ROUND_ROBIN(1'b0)) u_fix (
      .clk (clk), .rst (rst), .EN (en[0]),
      .D0 (d[0][0]), .D1 (d[0][1]), .D2 (d[0][2]), .D3 (d[0][3]),
      .ACK (ack[0]), .A1 (a1[0]), .A0 (a0[0]), .V (v[0]), .PEND (pend[0])
   );

   encoder_4to2_seq #(.ROUND_ROBIN(1'b1)) u_rr (
      .clk (clk), .rst (rst), .EN (en[1]),
      .D0 (d[1][0]), .D1 (d[1][1]), .D2 (d[1][2]), .D3 (d[1][3]),
      .ACK (ack[1]), .A1 (a1[1]), .A0 (a0[1]), .V (v[1]), .PEND (pend[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp_v);
      end
   endtask

   // Handshake monitor: a grant counts once, on the cycle it is accepted.
   always @(negedge clk) begin
      if (!rst && en[0] && v[0] && ack[0]) begin
         if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL fix_unexpected_grant: got code %0d, required no grant", {a1[0], a0[0]});
         end else chk("fix_grant_code", 32'({a1[0], a0[0]}), 32'(q0.pop_front()));
      end
      if (!rst && en[1] && v[1] && ack[1]) begin
         if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rr_unexpected_grant: got code %0d, required no grant", {a1[1], a0[1]});
         end else chk("rr_grant_code", 32'({a1[1], a0[1]}), 32'(q1.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input int u, input string nm, input logic [3:0] p, input logic vv,
                            input logic [1:0] c);
      chk({nm, "_pend"}, 32'(pend[u]), 32'(p));
      chk({nm, "_v"}, 32'(v[u]), 32'(vv));
      chk({nm, "_code"}, 32'({a1[u], a0[u]}), 32'(c));
   endtask

   task automatic grant_ack(input int u, input int c);
      int t;
      t = 0;
      if (u == 0) q0.push_back(c); else q1.push_back(c);
      while (v[u] !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      if (v[u] !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL grant_timeout dut%0d: V got %b, required 1 for code %0d", u, v[u], c);
         if (u == 0) void'(q0.pop_back()); else void'(q1.pop_back());
      end else begin
         ack[u] = 1'b1;
         tick();
         ack[u] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time got 200000, required earlier finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         en[u] = 1'b1; d[u] = 4'b0000; ack[u] = 1'b0;
      end
      tick(); tick();
      rst = 1'b0;
      chk_state(0, "reset_fix", 4'b0000, 1'b0, 2'b00);
      chk_state(1, "reset_rr",  4'b0000, 1'b0, 2'b00);

      // Single request on D1 with latency checks.
      d[0] = 4'b0010; tick(); d[0] = 4'b0000;
      chk_state(0, "d1_pend", 4'b0010, 1'b0, 2'b00);
      tick();
      chk_state(0, "d1_grant", 4'b0010, 1'b1, 2'b01);
      grant_ack(0, 1);
      chk_state(0, "d1_acked", 4'b0000, 1'b0, 2'b01);

      // Fixed priority: D2 beats D0, then D0, then nothing.
      d[0] = 4'b0101; tick(); d[0] = 4'b0000;
      grant_ack(0, 2);
      grant_ack(0, 0);
      tick(); tick();
      chk("fixed_drain_v", 32'(v[0]), 32'd0);
      chk("fixed_drain_pend", 32'(pend[0]), 32'd0);

      // Collision: held D2 re-pends across its own ACK.
      d[0] = 4'b0100;
      grant_ack(0, 2);
      chk("collide_pend", 32'(pend[0]), 32'b0100);
      chk("collide_v_low", 32'(v[0]), 32'd0);
      tick();
      chk("collide_v_again", 32'(v[0]), 32'd1);
      chk("collide_code", 32'({a1[0], a0[0]}), 32'd2);
      d[0] = 4'b0000;
      grant_ack(0, 2);
      chk("collide_drain", 32'(pend[0]), 32'd0);

      // Enable flush, with a D0 pulse during EN=0 that must be lost.
      d[0] = 4'b1010; tick(); d[0] = 4'b0000; tick();
      chk_state(0, "flush_pre", 4'b1010, 1'b1, 2'b11);
      en[0] = 1'b0; d[0] = 4'b0001; tick();
      chk_state(0, "flush_now", 4'b0000, 1'b0, 2'b00);
      d[0] = 4'b0000; tick();
      en[0] = 1'b1; tick();
      chk_state(0, "flush_after", 4'b0000, 1'b0, 2'b00);

      // Reset while holding a grant.
      d[0] = 4'b1000; tick(); d[0] = 4'b0000; tick();
      chk("hold_before_rst", 32'(v[0]), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_state(0, "rst_hold", 4'b0000, 1'b0, 2'b00);

      // Stray ACK while idle.
      ack[0] = 1'b1; tick(); ack[0] = 1'b0; tick();
      chk_state(0, "stray_ack", 4'b0000, 1'b0, 2'b00);

      // Round robin: all lines held, then released and drained.
      d[1] = 4'b1111;
      grant_ack(1, 0);
      grant_ack(1, 1);
      grant_ack(1, 2);
      grant_ack(1, 3);
      grant_ack(1, 0);
      d[1] = 4'b0000;
      chk("rr_pend_full", 32'(pend[1]), 32'b1111);
      grant_ack(1, 1);
      grant_ack(1, 2);
      grant_ack(1, 3);
      grant_ack(1, 0);
      tick(); tick();
      chk_state(1, "rr_drained", 4'b0000, 1'b0, 2'b00);

      tick();
      chk("fix_queue_empty", 32'(q0.size()), 32'd0);
      chk("rr_queue_empty", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
